// File: rtl/mvm_job_sched_if.sv
// Job descriptor port of the MVM scheduler: host-side valid/ready handshake
// carrying the descriptor fields, plus the tag assigned on acceptance.
interface mvm_job_sched_if #(
    parameter int unsigned VEC_ADDRW = 8,
    parameter int unsigned MAT_ADDRW = 9,
    parameter int unsigned TAGW      = 4
);
    logic                 job_valid;
    logic                 job_ready;
    logic [VEC_ADDRW-1:0] job_vec_addr;
    logic [VEC_ADDRW:0]   job_vec_words;
    logic [MAT_ADDRW-1:0] job_mat_addr;
    logic [MAT_ADDRW:0]   job_mat_rows;
    logic [TAGW-1:0]      job_tag;

    modport master (
        output job_valid, job_vec_addr, job_vec_words, job_mat_addr, job_mat_rows,
        input  job_ready, job_tag
    );

    modport slave (
        input  job_valid, job_vec_addr, job_vec_words, job_mat_addr, job_mat_rows,
        output job_ready, job_tag
    );
endinterface

// File: rtl/mvm_job_sched.sv
// Job scheduler: descriptor FIFO plus launch/run/drain FSM in front of the MVM engine.
// Optional per-state watchdog enabled by defining MVM_SCHED_WDOG_EN.
module mvm_job_sched #(
    parameter int unsigned VEC_ADDRW   = 8,
    parameter int unsigned MAT_ADDRW   = 9,
    parameter int unsigned QDEPTH      = 4,
    parameter int unsigned TAGW        = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    mvm_job_sched_if.slave           job,
    output logic                     o_start,
    output logic [VEC_ADDRW-1:0]     o_vec_addr,
    output logic [VEC_ADDRW:0]       o_vec_words,
    output logic [MAT_ADDRW-1:0]     o_mat_addr,
    output logic [MAT_ADDRW:0]       o_mat_rows,
    input  logic                     i_mvm_busy,
    input  logic                     i_mvm_valid,
    output logic                     o_done,
    output logic [TAGW-1:0]          o_done_tag,
    output logic                     o_err,
    output logic                     o_idle,
    output logic [$clog2(QDEPTH):0]  o_pending
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = MAT_ADDRW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [TAGW-1:0]      tag;
        logic [VEC_ADDRW-1:0] vec_addr;
        logic [VEC_ADDRW:0]   vec_words;
        logic [MAT_ADDRW-1:0] mat_addr;
        logic [MAT_ADDRW:0]   mat_rows;
    } desc_t;

    desc_t          mem_q [QDEPTH];
    desc_t          din;
    desc_t          head;
    desc_t          cfg_q, cfg_d;
    state_t         state_q, state_d;
    logic [CW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic           start_q, start_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           full, empty, accept, reject, push, in_job;

`ifdef MVM_SCHED_WDOG_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] wdog_q, wdog_d;
`endif

    always_comb begin
        count  = wr_ptr_q - rd_ptr_q;
        full   = (count == FULL_CNT);
        empty  = (count == '0);
        accept = job.job_valid && !full;
        reject = accept && ((job.job_vec_words == '0) || (job.job_mat_rows == '0));
        push   = accept && !reject;
        din    = '{tag:       tag_q,
                   vec_addr:  job.job_vec_addr,
                   vec_words: job.job_vec_words,
                   mat_addr:  job.job_mat_addr,
                   mat_rows:  job.job_mat_rows};
        head   = mem_q[rd_ptr_q[PW-1:0]];
        in_job = (state_q == S_WAIT_BUSY) || (state_q == S_RUN) || (state_q == S_DRAIN);
    end

    always_comb begin
        job.job_ready = !full;
        job.job_tag   = tag_q;
        o_start       = start_q;
        o_vec_addr    = cfg_q.vec_addr;
        o_vec_words   = cfg_q.vec_words;
        o_mat_addr    = cfg_q.mat_addr;
        o_mat_rows    = cfg_q.mat_rows;
        o_done        = done_q;
        o_done_tag    = cfg_q.tag;
        o_err         = err_q;
        o_idle        = (state_q == S_IDLE) && empty;
        o_pending     = count;
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q + CW'(push);
        rd_ptr_d = rd_ptr_q;
        tag_d    = tag_q + TAGW'(accept);
        cfg_d    = cfg_q;
        beat_d   = beat_q;
        err_d    = reject;

        // Beats are judged against the registered state, so a beat landing on a transition still counts.
        if (i_mvm_valid) begin
            if (in_job && (beat_q != cfg_q.mat_rows)) begin
                if (beat_q != '1) begin
                    beat_d = beat_q + BW'(1);
                end
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                // Config is captured on entry to LAUNCH so it is already valid alongside o_start.
                if (!empty) begin
                    state_d = S_LAUNCH;
                    cfg_d   = head;
                end
            end
            S_LAUNCH: begin
                rd_ptr_d = rd_ptr_q + CW'(1);
                beat_d   = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: if (i_mvm_busy) state_d = S_RUN;
            S_RUN:       if (!i_mvm_busy) state_d = S_DRAIN;
            S_DRAIN:     if (beat_q == cfg_q.mat_rows) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

`ifdef MVM_SCHED_WDOG_EN
        wdog_d = '0;
        if (in_job && (state_d == state_q)) begin
            if (wdog_q == WDW'(TIMEOUT_CYC - 1)) begin
                state_d = S_DONE;
                err_d   = 1'b1;
            end else begin
                wdog_d = wdog_q + WDW'(1);
            end
        end
`endif

        start_d = (state_d == S_LAUNCH);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tag_q    <= '0;
            cfg_q    <= '0;
            beat_q   <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef MVM_SCHED_WDOG_EN
            wdog_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tag_q    <= tag_d;
            cfg_q    <= cfg_d;
            beat_q   <= beat_d;
            start_q  <= start_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef MVM_SCHED_WDOG_EN
            wdog_q   <= wdog_d;
`endif
        end
    end
endmodule

// File: tb/tb_mvm_job_sched.sv
// Directed self-checking bench for mvm_job_sched; the watchdog case is built
// only when MVM_SCHED_WDOG_EN is defined.
`timescale 1ns/1ps
module tb_mvm_job_sched;
    localparam int unsigned VEC_ADDRW   = 8;
    localparam int unsigned MAT_ADDRW   = 9;
    localparam int unsigned QDEPTH      = 4;
    localparam int unsigned TAGW        = 4;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_mvm_busy = 1'b0;
    logic                 i_mvm_valid = 1'b0;
    logic                 o_start;
    logic [VEC_ADDRW-1:0] o_vec_addr;
    logic [VEC_ADDRW:0]   o_vec_words;
    logic [MAT_ADDRW-1:0] o_mat_addr;
    logic [MAT_ADDRW:0]   o_mat_rows;
    logic                 o_done;
    logic [TAGW-1:0]      o_done_tag;
    logic                 o_err;
    logic                 o_idle;
    logic [2:0]           o_pending;

    mvm_job_sched_if #(.VEC_ADDRW(VEC_ADDRW), .MAT_ADDRW(MAT_ADDRW), .TAGW(TAGW)) job ();

    mvm_job_sched #(
        .VEC_ADDRW(VEC_ADDRW), .MAT_ADDRW(MAT_ADDRW), .QDEPTH(QDEPTH),
        .TAGW(TAGW), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .job(job),
        .o_start(o_start), .o_vec_addr(o_vec_addr), .o_vec_words(o_vec_words),
        .o_mat_addr(o_mat_addr), .o_mat_rows(o_mat_rows),
        .i_mvm_busy(i_mvm_busy), .i_mvm_valid(i_mvm_valid),
        .o_done(o_done), .o_done_tag(o_done_tag), .o_err(o_err),
        .o_idle(o_idle), .o_pending(o_pending)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   starts_seen = 0;
    int   dones_seen = 0;
    int   overlap = 0;
    logic inflight = 1'b0;

    // Launch/completion tracker sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            starts_seen = 0;
            dones_seen  = 0;
            inflight    = 1'b0;
        end else begin
            if (o_start) begin
                if (inflight) overlap++;
                inflight = 1'b1;
                starts_seen++;
            end
            if (o_done) begin
                inflight = 1'b0;
                dones_seen++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        job.job_valid     = 1'b0;
        job.job_vec_addr  = '0;
        job.job_vec_words = '0;
        job.job_mat_addr  = '0;
        job.job_mat_rows  = '0;
        i_mvm_busy        = 1'b0;
        i_mvm_valid       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_job(input logic [7:0] va, input logic [8:0] vw,
                           input logic [8:0] ma, input logic [9:0] mr);
        job.job_valid     = 1'b1;
        job.job_vec_addr  = va;
        job.job_vec_words = vw;
        job.job_mat_addr  = ma;
        job.job_mat_rows  = mr;
    endtask

    // Waits for launch number idx, checks config, models busy then one beat per row.
    task automatic run_job(input int idx, input logic [3:0] exp_tag, input logic [7:0] exp_va,
                           input logic [9:0] rows, input int busy_n);
        int guard;
        guard = 0;
        while (starts_seen <= idx && guard < 40) begin
            tick();
            guard++;
        end
        check("launch_seen", 32'(starts_seen > idx), 32'(1));
        check("cfg_vec_addr", 32'(o_vec_addr), 32'(exp_va));
        check("cfg_mat_rows", 32'(o_mat_rows), 32'(rows));
        i_mvm_busy = 1'b1;
        repeat (busy_n) tick();
        i_mvm_busy  = 1'b0;
        i_mvm_valid = 1'b1;
        repeat (rows) tick();
        i_mvm_valid = 1'b0;
        guard = 0;
        while (!o_done && guard < 10) begin
            tick();
            guard++;
        end
        check("done_tag", 32'({o_done, o_done_tag}), 32'({1'b1, exp_tag}));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // 1: reset / idle
        do_reset();
        check("t1_ready", 32'(job.job_ready), 32'(1));
        check("t1_idle", 32'(o_idle), 32'(1));
        check("t1_start", 32'(o_start), 32'(0));
        check("t1_pending", 32'(o_pending), 32'(0));
        check("t1_done_err", 32'({o_done, o_err}), 32'(0));

        // 2: single job with exact latencies
        set_job(8'h10, 9'd4, 9'h20, 10'd3);
        check("t2_tag", 32'(job.job_tag), 32'(0));
        tick();
        job.job_valid = 1'b0;
        check("t2_nostart_yet", 32'(o_start), 32'(0));
        check("t2_pending", 32'(o_pending), 32'(1));
        tick();
        check("t2_start", 32'(o_start), 32'(1));
        check("t2_vec_addr", 32'(o_vec_addr), 32'h10);
        check("t2_vec_words", 32'(o_vec_words), 32'(4));
        check("t2_mat_addr", 32'(o_mat_addr), 32'h20);
        check("t2_mat_rows", 32'(o_mat_rows), 32'(3));
        tick();
        check("t2_start_pulse", 32'(o_start), 32'(0));
        i_mvm_busy = 1'b1;
        repeat (12) tick();
        check("t2_no_early_done", 32'(o_done), 32'(0));
        i_mvm_busy  = 1'b0;
        i_mvm_valid = 1'b1;
        repeat (3) tick();
        i_mvm_valid = 1'b0;
        check("t2_done_not_same", 32'(o_done), 32'(0));
        tick();
        check("t2_done", 32'({o_done, o_done_tag}), 32'({1'b1, 4'd0}));
        check("t2_err_clean", 32'(o_err), 32'(0));
        tick();
        check("t2_done_pulse", 32'(o_done), 32'(0));
        check("t2_idle", 32'(o_idle), 32'(1));

        // 3: five back-to-back jobs, FIFO fills, ordered completion
        do_reset();
        for (int k = 0; k < 5; k++) begin
            int g;
            set_job(8'(8'h40 + k), 9'd1, 9'(k), 10'd2);
            g = 0;
            while (!job.job_ready && g < 20) begin
                tick();
                g++;
            end
            check("t3_tag", 32'(job.job_tag), 32'(k));
            tick();
        end
        job.job_valid = 1'b0;
        check("t3_ready_full", 32'(job.job_ready), 32'(0));
        check("t3_pending", 32'(o_pending), 32'(4));
        for (int k = 0; k < 5; k++) begin
            run_job(k, 4'(k), 8'(8'h40 + k), 10'd2, 3);
        end
        check("t3_starts", 32'(starts_seen), 32'(5));
        check("t3_dones", 32'(dones_seen), 32'(5));
        check("t3_no_overlap", 32'(overlap), 32'(0));

        // 4: rows==0 rejected, tag consumed
        do_reset();
        set_job(8'h01, 9'd2, 9'h02, 10'd0);
        check("t4_rej_tag", 32'(job.job_tag), 32'(0));
        tick();
        job.job_valid = 1'b0;
        check("t4_err", 32'(o_err), 32'(1));
        check("t4_not_queued", 32'(o_pending), 32'(0));
        check("t4_idle", 32'(o_idle), 32'(1));
        tick();
        check("t4_err_pulse", 32'(o_err), 32'(0));
        set_job(8'h55, 9'd2, 9'h03, 10'd1);
        check("t4_next_tag", 32'(job.job_tag), 32'(1));
        tick();
        job.job_valid = 1'b0;
        run_job(0, 4'd1, 8'h55, 10'd1, 2);

        // 5: stray beats and mid-run reset
        do_reset();
        i_mvm_valid = 1'b1;
        tick();
        i_mvm_valid = 1'b0;
        check("t5_stray_idle_err", 32'(o_err), 32'(1));
        check("t5_stray_idle", 32'(o_idle), 32'(1));
        tick();
        check("t5_err_pulse", 32'(o_err), 32'(0));
        set_job(8'h66, 9'd1, 9'h04, 10'd1);
        tick();
        job.job_valid = 1'b0;
        tick();
        check("t5_start", 32'(o_start), 32'(1));
        tick();
        i_mvm_busy = 1'b1;
        tick();
        i_mvm_busy  = 1'b0;
        i_mvm_valid = 1'b1;
        tick();
        check("t5_no_err_counted", 32'(o_err), 32'(0));
        tick();
        i_mvm_valid = 1'b0;
        check("t5_done_and_excess_err", 32'({o_done, o_err}), 32'(3));
        tick();
        set_job(8'h77, 9'd1, 9'h05, 10'd2);
        tick();
        job.job_valid = 1'b0;
        repeat (2) tick();
        i_mvm_busy = 1'b1;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_outs", 32'({o_start, o_done, o_err, o_done_tag}), 32'(0));
        check("t5_rst_cfg", 32'({o_vec_addr, o_mat_rows}), 32'(0));
        check("t5_rst_status", 32'({job.job_ready, o_idle, o_pending}), 32'({2'b11, 3'd0}));
        i_mvm_busy = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (6) tick();
        check("t5_no_done_after_rst", 32'(dones_seen), 32'(0));

`ifdef MVM_SCHED_WDOG_EN
        // 6: watchdog expiry in WAIT_BUSY, next job still launches
        do_reset();
        set_job(8'h30, 9'd1, 9'h06, 10'd1);
        tick();
        set_job(8'h31, 9'd1, 9'h07, 10'd1);
        tick();
        job.job_valid = 1'b0;
        check("t6_start0", 32'(o_start), 32'(1));
        repeat (16) tick();
        check("t6_no_early_timeout", 32'({o_done, o_err}), 32'(0));
        tick();
        check("t6_timeout", 32'({o_done, o_err, o_done_tag}), 32'({2'b11, 4'd0}));
        check("t6_fifo_kept", 32'(o_pending), 32'(1));
        repeat (2) tick();
        check("t6_next_launch", 32'({o_start, o_vec_addr}), 32'({1'b1, 8'h31}));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
